aes_key_expand: RTL and testbench

- Iterative AES-128 key-schedule generator upstream of the cipher round datapath.
- On a load request it latches the 128-bit cipher key and presents round key 0 on w0..w3.
- It then produces one new round key per clock until round 10.
- w0..w3 drive the cipher core's w0..w3 round-key inputs directly; ld and key are shared with the core.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_sbox.sv | 30 +++
 rtl/aes_key_expand.sv | 121 ++++++++++++
 tb/tb_aes_key_expand.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and helper functions for the key schedule and round datapath.
package aes_pkg;

  typedef logic [31:0] aes_word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } kx_state_t;

  localparam int NR_128 = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  // GF(2^8) multiply by x, reducing with the AES polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box; shared by SubWord here and SubBytes in the round datapath.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  always_comb begin
    dout = 8'h00;
    case (din)
      8'h00: dout = 8'h63; 8'h01: dout = 8'h7c; 8'h02: dout = 8'h77; 8'h03: dout = 8'h7b; 8'h04: dout = 8'hf2; 8'h05: dout = 8'h6b; 8'h06: dout = 8'h6f; 8'h07: dout = 8'hc5; 8'h08: dout = 8'h30; 8'h09: dout = 8'h01; 8'h0a: dout = 8'h67; 8'h0b: dout = 8'h2b; 8'h0c: dout = 8'hfe; 8'h0d: dout = 8'hd7; 8'h0e: dout = 8'hab; 8'h0f: dout = 8'h76;
      8'h10: dout = 8'hca; 8'h11: dout = 8'h82; 8'h12: dout = 8'hc9; 8'h13: dout = 8'h7d; 8'h14: dout = 8'hfa; 8'h15: dout = 8'h59; 8'h16: dout = 8'h47; 8'h17: dout = 8'hf0; 8'h18: dout = 8'had; 8'h19: dout = 8'hd4; 8'h1a: dout = 8'ha2; 8'h1b: dout = 8'haf; 8'h1c: dout = 8'h9c; 8'h1d: dout = 8'ha4; 8'h1e: dout = 8'h72; 8'h1f: dout = 8'hc0;
      8'h20: dout = 8'hb7; 8'h21: dout = 8'hfd; 8'h22: dout = 8'h93; 8'h23: dout = 8'h26; 8'h24: dout = 8'h36; 8'h25: dout = 8'h3f; 8'h26: dout = 8'hf7; 8'h27: dout = 8'hcc; 8'h28: dout = 8'h34; 8'h29: dout = 8'ha5; 8'h2a: dout = 8'he5; 8'h2b: dout = 8'hf1; 8'h2c: dout = 8'h71; 8'h2d: dout = 8'hd8; 8'h2e: dout = 8'h31; 8'h2f: dout = 8'h15;
      8'h30: dout = 8'h04; 8'h31: dout = 8'hc7; 8'h32: dout = 8'h23; 8'h33: dout = 8'hc3; 8'h34: dout = 8'h18; 8'h35: dout = 8'h96; 8'h36: dout = 8'h05; 8'h37: dout = 8'h9a; 8'h38: dout = 8'h07; 8'h39: dout = 8'h12; 8'h3a: dout = 8'h80; 8'h3b: dout = 8'he2; 8'h3c: dout = 8'heb; 8'h3d: dout = 8'h27; 8'h3e: dout = 8'hb2; 8'h3f: dout = 8'h75;
      8'h40: dout = 8'h09; 8'h41: dout = 8'h83; 8'h42: dout = 8'h2c; 8'h43: dout = 8'h1a; 8'h44: dout = 8'h1b; 8'h45: dout = 8'h6e; 8'h46: dout = 8'h5a; 8'h47: dout = 8'ha0; 8'h48: dout = 8'h52; 8'h49: dout = 8'h3b; 8'h4a: dout = 8'hd6; 8'h4b: dout = 8'hb3; 8'h4c: dout = 8'h29; 8'h4d: dout = 8'he3; 8'h4e: dout = 8'h2f; 8'h4f: dout = 8'h84;
      8'h50: dout = 8'h53; 8'h51: dout = 8'hd1; 8'h52: dout = 8'h00; 8'h53: dout = 8'hed; 8'h54: dout = 8'h20; 8'h55: dout = 8'hfc; 8'h56: dout = 8'hb1; 8'h57: dout = 8'h5b; 8'h58: dout = 8'h6a; 8'h59: dout = 8'hcb; 8'h5a: dout = 8'hbe; 8'h5b: dout = 8'h39; 8'h5c: dout = 8'h4a; 8'h5d: dout = 8'h4c; 8'h5e: dout = 8'h58; 8'h5f: dout = 8'hcf;
      8'h60: dout = 8'hd0; 8'h61: dout = 8'hef; 8'h62: dout = 8'haa; 8'h63: dout = 8'hfb; 8'h64: dout = 8'h43; 8'h65: dout = 8'h4d; 8'h66: dout = 8'h33; 8'h67: dout = 8'h85; 8'h68: dout = 8'h45; 8'h69: dout = 8'hf9; 8'h6a: dout = 8'h02; 8'h6b: dout = 8'h7f; 8'h6c: dout = 8'h50; 8'h6d: dout = 8'h3c; 8'h6e: dout = 8'h9f; 8'h6f: dout = 8'ha8;
      8'h70: dout = 8'h51; 8'h71: dout = 8'ha3; 8'h72: dout = 8'h40; 8'h73: dout = 8'h8f; 8'h74: dout = 8'h92; 8'h75: dout = 8'h9d; 8'h76: dout = 8'h38; 8'h77: dout = 8'hf5; 8'h78: dout = 8'hbc; 8'h79: dout = 8'hb6; 8'h7a: dout = 8'hda; 8'h7b: dout = 8'h21; 8'h7c: dout = 8'h10; 8'h7d: dout = 8'hff; 8'h7e: dout = 8'hf3; 8'h7f: dout = 8'hd2;
      8'h80: dout = 8'hcd; 8'h81: dout = 8'h0c; 8'h82: dout = 8'h13; 8'h83: dout = 8'hec; 8'h84: dout = 8'h5f; 8'h85: dout = 8'h97; 8'h86: dout = 8'h44; 8'h87: dout = 8'h17; 8'h88: dout = 8'hc4; 8'h89: dout = 8'ha7; 8'h8a: dout = 8'h7e; 8'h8b: dout = 8'h3d; 8'h8c: dout = 8'h64; 8'h8d: dout = 8'h5d; 8'h8e: dout = 8'h19; 8'h8f: dout = 8'h73;
      8'h90: dout = 8'h60; 8'h91: dout = 8'h81; 8'h92: dout = 8'h4f; 8'h93: dout = 8'hdc; 8'h94: dout = 8'h22; 8'h95: dout = 8'h2a; 8'h96: dout = 8'h90; 8'h97: dout = 8'h88; 8'h98: dout = 8'h46; 8'h99: dout = 8'hee; 8'h9a: dout = 8'hb8; 8'h9b: dout = 8'h14; 8'h9c: dout = 8'hde; 8'h9d: dout = 8'h5e; 8'h9e: dout = 8'h0b; 8'h9f: dout = 8'hdb;
      8'ha0: dout = 8'he0; 8'ha1: dout = 8'h32; 8'ha2: dout = 8'h3a; 8'ha3: dout = 8'h0a; 8'ha4: dout = 8'h49; 8'ha5: dout = 8'h06; 8'ha6: dout = 8'h24; 8'ha7: dout = 8'h5c; 8'ha8: dout = 8'hc2; 8'ha9: dout = 8'hd3; 8'haa: dout = 8'hac; 8'hab: dout = 8'h62; 8'hac: dout = 8'h91; 8'had: dout = 8'h95; 8'hae: dout = 8'he4; 8'haf: dout = 8'h79;
      8'hb0: dout = 8'he7; 8'hb1: dout = 8'hc8; 8'hb2: dout = 8'h37; 8'hb3: dout = 8'h6d; 8'hb4: dout = 8'h8d; 8'hb5: dout = 8'hd5; 8'hb6: dout = 8'h4e; 8'hb7: dout = 8'ha9; 8'hb8: dout = 8'h6c; 8'hb9: dout = 8'h56; 8'hba: dout = 8'hf4; 8'hbb: dout = 8'hea; 8'hbc: dout = 8'h65; 8'hbd: dout = 8'h7a; 8'hbe: dout = 8'hae; 8'hbf: dout = 8'h08;
      8'hc0: dout = 8'hba; 8'hc1: dout = 8'h78; 8'hc2: dout = 8'h25; 8'hc3: dout = 8'h2e; 8'hc4: dout = 8'h1c; 8'hc5: dout = 8'ha6; 8'hc6: dout = 8'hb4; 8'hc7: dout = 8'hc6; 8'hc8: dout = 8'he8; 8'hc9: dout = 8'hdd; 8'hca: dout = 8'h74; 8'hcb: dout = 8'h1f; 8'hcc: dout = 8'h4b; 8'hcd: dout = 8'hbd; 8'hce: dout = 8'h8b; 8'hcf: dout = 8'h8a;
      8'hd0: dout = 8'h70; 8'hd1: dout = 8'h3e; 8'hd2: dout = 8'hb5; 8'hd3: dout = 8'h66; 8'hd4: dout = 8'h48; 8'hd5: dout = 8'h03; 8'hd6: dout = 8'hf6; 8'hd7: dout = 8'h0e; 8'hd8: dout = 8'h61; 8'hd9: dout = 8'h35; 8'hda: dout = 8'h57; 8'hdb: dout = 8'hb9; 8'hdc: dout = 8'h86; 8'hdd: dout = 8'hc1; 8'hde: dout = 8'h1d; 8'hdf: dout = 8'h9e;
      8'he0: dout = 8'he1; 8'he1: dout = 8'hf8; 8'he2: dout = 8'h98; 8'he3: dout = 8'h11; 8'he4: dout = 8'h69; 8'he5: dout = 8'hd9; 8'he6: dout = 8'h8e; 8'he7: dout = 8'h94; 8'he8: dout = 8'h9b; 8'he9: dout = 8'h1e; 8'hea: dout = 8'h87; 8'heb: dout = 8'he9; 8'hec: dout = 8'hce; 8'hed: dout = 8'h55; 8'hee: dout = 8'h28; 8'hef: dout = 8'hdf;
      8'hf0: dout = 8'h8c; 8'hf1: dout = 8'ha1; 8'hf2: dout = 8'h89; 8'hf3: dout = 8'h0d; 8'hf4: dout = 8'hbf; 8'hf5: dout = 8'he6; 8'hf6: dout = 8'h42; 8'hf7: dout = 8'h68; 8'hf8: dout = 8'h41; 8'hf9: dout = 8'h99; 8'hfa: dout = 8'h2d; 8'hfb: dout = 8'h0f; 8'hfc: dout = 8'hb0; 8'hfd: dout = 8'h54; 8'hfe: dout = 8'hbb; 8'hff: dout = 8'h16;
      default: dout = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock after ld.
// Define AES_KEY_CACHE_EN to add an 11-entry round-key store with a read port.
module aes_key_expand #(
  parameter int         NR        = 10,
  parameter logic [7:0] RCON_INIT = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key,
  output logic [31:0]  w0,
  output logic [31:0]  w1,
  output logic [31:0]  w2,
  output logic [31:0]  w3,
  output logic [3:0]   round,
  output logic         busy,
  output logic         kdone
`ifdef AES_KEY_CACHE_EN
  ,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key,
  output logic         rd_valid
`endif
);

  import aes_pkg::*;

  if (NR != NR_128) begin : g_nr_check
    $error("aes_key_expand: only NR=10 (AES-128) is supported");
  end

  kx_state_t  state;
  logic [7:0] rcon;
  aes_word_t  rot;
  aes_word_t  sub;
  aes_word_t  t;
  aes_word_t  nw0, nw1, nw2, nw3;
  logic       last_step;

  assign rot = rot_word(w3);

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .din  (rot[8*i +: 8]),
      .dout (sub[8*i +: 8])
    );
  end

  always_comb begin
    t   = sub ^ {rcon, 24'h000000};
    nw0 = w0 ^ t;
    nw1 = w1 ^ nw0;
    nw2 = w2 ^ nw1;
    nw3 = w3 ^ nw2;
  end

  assign last_step = (round == 4'(NR - 1));

  // ld restarts from any state and overrides an advance on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      w0    <= '0;
      w1    <= '0;
      w2    <= '0;
      w3    <= '0;
      round <= '0;
      busy  <= 1'b0;
      kdone <= 1'b0;
      rcon  <= RCON_INIT;
    end else if (ld) begin
      state <= EXPAND;
      w0    <= key[127:96];
      w1    <= key[95:64];
      w2    <= key[63:32];
      w3    <= key[31:0];
      round <= '0;
      busy  <= 1'b1;
      kdone <= 1'b0;
      rcon  <= RCON_INIT;
    end else begin
      case (state)
        EXPAND: begin
          w0    <= nw0;
          w1    <= nw1;
          w2    <= nw2;
          w3    <= nw3;
          round <= round + 4'd1;
          rcon  <= xtime(rcon);
          if (last_step) begin
            state <= DONE;
            busy  <= 1'b0;
            kdone <= 1'b1;
          end
        end
        default: state <= state;
      endcase
    end
  end

`ifdef AES_KEY_CACHE_EN
  logic [127:0] key_store [0:NR_128];

  // Each produced round key lands at its round index, so the store mirrors the schedule.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= NR_128; i++) key_store[i] <= '0;
      rd_valid <= 1'b0;
    end else if (ld) begin
      key_store[0] <= key;
      rd_valid     <= 1'b0;
    end else if (state == EXPAND) begin
      key_store[round + 4'd1] <= {nw0, nw1, nw2, nw3};
      if (last_step) rd_valid <= 1'b1;
    end
  end

  assign rd_key = (rd_addr > 4'(NR_128)) ? '0 : key_store[rd_addr];
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed self-checking bench for aes_key_expand using FIPS-197 and all-zero key vectors.
module tb_aes_key_expand;

  logic         clk;
  logic         rst;
  logic         ld;
  logic [127:0] key;
  logic [31:0]  w0, w1, w2, w3;
  logic [3:0]   round;
  logic         busy;
  logic         kdone;
`ifdef AES_KEY_CACHE_EN
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;
  logic         rd_valid;
`endif

  int checkCount;
  int failCount;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .key      (key),
    .w0       (w0),
    .w1       (w1),
    .w2       (w2),
    .w3       (w3),
    .round    (round),
    .busy     (busy),
    .kdone    (kdone)
`ifdef AES_KEY_CACHE_EN
    ,
    .rd_addr  (rd_addr),
    .rd_key   (rd_key),
    .rd_valid (rd_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one edge with the given ld/key, then drop ld.
  task automatic applyStimulus(input logic ldVal, input logic [127:0] keyVal);
    ld  = ldVal;
    key = keyVal;
    stepCycle();
    ld  = 1'b0;
  endtask

  function automatic logic [127:0] roundKey();
    return {w0, w1, w2, w3};
  endfunction

  task automatic checkStatus(input string tag, input int expRound, input logic expBusy, input logic expDone);
    checkOutput({tag, "_round"}, 128'(round), 128'(expRound));
    checkOutput({tag, "_busy"},  128'(busy),  128'(expBusy));
    checkOutput({tag, "_kdone"}, 128'(kdone), 128'(expDone));
  endtask

  logic [127:0] heldKey;

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst = 1'b0;
    ld  = 1'b0;
    key = '0;
`ifdef AES_KEY_CACHE_EN
    rd_addr = '0;
`endif
    #12;
    checkOutput("reset_w", roundKey(), 128'h0);
    checkStatus("reset", 0, 1'b0, 1'b0);
    rst = 1'b1;
    stepCycle();
    stepCycle();
    checkStatus("idle_no_ld", 0, 1'b0, 1'b0);

    $display("[TB] FIPS-197 A.1 expansion");
    applyStimulus(1'b1, FIPS_KEY);
    checkOutput("fips_r0", roundKey(), FIPS_KEY);
    checkStatus("fips_r0", 0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 128'hdeadbeef_00000000_12345678_9abcdef0);
      checkOutput("fips_kdone_timing", 128'(kdone), 128'(k == 10));
      checkOutput("fips_busy_timing",  128'(busy),  128'(k != 10));
      checkOutput("fips_round_idx",    128'(round), 128'(k));
      if (k == 1)  checkOutput("fips_r1", roundKey(), FIPS_R1);
      if (k == 2)  checkOutput("fips_r2", roundKey(), FIPS_R2);
      if (k == 10) checkOutput("fips_r10", roundKey(), FIPS_R10);
    end

`ifdef AES_KEY_CACHE_EN
    checkOutput("cache_valid", 128'(rd_valid), 128'h1);
    rd_addr = 4'd0;  #1; checkOutput("cache_r0", rd_key, FIPS_KEY);
    rd_addr = 4'd1;  #1; checkOutput("cache_r1", rd_key, FIPS_R1);
    rd_addr = 4'd10; #1; checkOutput("cache_r10", rd_key, FIPS_R10);
    rd_addr = 4'd15; #1; checkOutput("cache_oob", rd_key, 128'h0);
`endif

    $display("[TB] hold after kdone");
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, 128'(k) * 128'h0101_0101);
    checkOutput("hold_w", roundKey(), FIPS_R10);
    checkStatus("hold", 10, 1'b0, 1'b1);

    $display("[TB] zero key");
    applyStimulus(1'b1, 128'h0);
    checkStatus("zero_r0", 0, 1'b1, 1'b0);
`ifdef AES_KEY_CACHE_EN
    checkOutput("cache_valid_clr", 128'(rd_valid), 128'h0);
`endif
    applyStimulus(1'b0, '0);
    checkOutput("zero_r1", roundKey(), ZERO_R1);
    for (int k = 2; k <= 10; k++) applyStimulus(1'b0, '0);
    checkOutput("zero_r10", roundKey(), ZERO_R10);
    checkStatus("zero_done", 10, 1'b0, 1'b1);

    $display("[TB] back-to-back ld on DONE");
    applyStimulus(1'b1, FIPS_KEY);
    checkOutput("b2b_r0", roundKey(), FIPS_KEY);
    checkStatus("b2b_r0", 0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0);
    checkOutput("b2b_r1", roundKey(), FIPS_R1);

    $display("[TB] restart at round 4");
    for (int k = 2; k <= 4; k++) applyStimulus(1'b0, '0);
    checkOutput("restart_pre_round", 128'(round), 128'd4);
    applyStimulus(1'b1, 128'h0);
    checkOutput("restart_w", roundKey(), 128'h0);
    checkStatus("restart", 0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, FIPS_KEY);
      checkOutput("restart_kdone_timing", 128'(kdone), 128'(k == 10));
    end
    checkOutput("restart_r10", roundKey(), ZERO_R10);

    $display("[TB] ld on the last advance edge");
    applyStimulus(1'b1, FIPS_KEY);
    for (int k = 1; k <= 9; k++) applyStimulus(1'b0, '0);
    checkOutput("late_pre_round", 128'(round), 128'd9);
    applyStimulus(1'b1, 128'h0);
    checkOutput("late_w", roundKey(), 128'h0);
    checkStatus("late_ld", 0, 1'b1, 1'b0);

    $display("[TB] reset mid-expansion");
    applyStimulus(1'b1, FIPS_KEY);
    for (int k = 1; k <= 5; k++) applyStimulus(1'b0, '0);
    checkOutput("mid_pre_round", 128'(round), 128'd5);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_w", roundKey(), 128'h0);
    checkStatus("async_rst", 0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, FIPS_KEY);
    checkOutput("post_rst_w", roundKey(), 128'h0);
    checkStatus("post_rst", 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
